// File: rtl/seq_game_core.sv
// seq_game_core: memory-game sequencer. Plays a stored note sequence of growing
// length on tone/led, then checks the player's keypad echo note by note.
module seq_game_core #(
  parameter int NOTE_BITS     = 3,
  parameter int MAX_LEN       = 8,
  parameter int START_LEN     = 1,
  parameter int TICK_DIV      = 5000000,
  parameter int NOTE_TICKS    = 3,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 20,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4*MAX_LEN-1:0]     seq_in,
  input  logic                     load,
  input  logic                     start,
  input  logic                     key_valid,
  input  logic [NOTE_BITS:0]       key_code,
  output logic [NOTE_BITS:0]       tone,
  output logic [2**NOTE_BITS-1:0]  led,
  output logic                     busy,
  output logic                     accepting,
  output logic [3:0]               level,
  output logic [3:0]               lives_left,
  output logic [SCORE_W-1:0]       score,
  output logic                     miss,
  output logic                     seq_loaded,
  output logic                     game_win,
  output logic                     game_over
);

  localparam int NW     = NOTE_BITS + 1;
  localparam int LED_N  = 2**NOTE_BITS;
  localparam int SEQ_W  = MAX_LEN * NOTE_BITS;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_T1 = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int MAX_T  = (MAX_T1 > TIMEOUT_TICKS) ? MAX_T1 : TIMEOUT_TICKS;
  localparam int TK_W   = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [TK_W-1:0]  NOTE_LAST = TK_W'(NOTE_TICKS - 1);
  localparam logic [TK_W-1:0]  GAP_LAST  = TK_W'(GAP_TICKS - 1);
  localparam logic [TK_W-1:0]  TO_LAST   = TK_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PLAY_ON  = 4'd1,
    S_PLAY_GAP = 4'd2,
    S_WAIT_KEY = 4'd3,
    S_ECHO     = 4'd4,
    S_CHECK    = 4'd5,
    S_MISS     = 4'd6,
    S_WIN      = 4'd7,
    S_LOSE     = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [TK_W-1:0]    tick_q, tick_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [3:0]         idx_q, idx_d;
  logic [NW-1:0]      key_q, key_d;
  logic [3:0]         level_q, level_d;
  logic [3:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               loaded_q, loaded_d;
  logic               win_q, win_d;
  logic               over_q, over_d;
  logic [NW-1:0]      tone_q, tone_d;
  logic [LED_N-1:0]   led_q, led_d;
  logic               busy_q, busy_d;
  logic               acc_q, acc_d;
  logic               miss_q, miss_d;

  logic               active_s;
  logic               tick_end_s;
  logic [3:0]         last_idx_s;
  logic [SCORE_W:0]   score_sum_s;
  logic               unused_seq_bits_s;

  // The spare top bit of each seq_in nibble carries no note information.
  assign unused_seq_bits_s = ^seq_in;

  // Stored field k is played as note value field + 1, so 0 never matches.
  function automatic logic [NW-1:0] note_at(input logic [SEQ_W-1:0] s, input logic [3:0] i);
    logic [NW-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (i == 4'(k)) r = NW'(s[k*NOTE_BITS +: NOTE_BITS]) + NW'(1'b1);
    end
    return r;
  endfunction

  // Next-state logic, game bookkeeping and the per-state prescaler.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    key_d    = key_q;
    level_d  = level_q;
    lives_d  = lives_q;
    score_d  = score_q;
    seq_d    = seq_q;
    loaded_d = loaded_q;
    win_d    = win_q;
    over_d   = over_q;
    active_s    = !((state_q == S_IDLE) || (state_q == S_WIN) || (state_q == S_LOSE));
    tick_end_s  = (div_q == DIV_LAST);
    last_idx_s  = level_q - 4'd1;
    score_sum_s = {1'b0, score_q} + (SCORE_W+1)'(level_q);

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (load) begin
          for (int k = 0; k < MAX_LEN; k++) begin
            seq_d[k*NOTE_BITS +: NOTE_BITS] = seq_in[4*k +: NOTE_BITS];
          end
          loaded_d = 1'b1;
        end else begin
          loaded_d = loaded_q;
        end
        // A same-cycle load supplies the sequence for this start.
        if (start && (loaded_q || load)) begin
          state_d = S_PLAY_ON;
          level_d = 4'(START_LEN);
          lives_d = 4'(LIVES);
          score_d = '0;
          win_d   = 1'b0;
          over_d  = 1'b0;
          idx_d   = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_PLAY_ON: begin
        if (tick_end_s && (tick_q == NOTE_LAST)) state_d = S_PLAY_GAP;
        else state_d = state_q;
      end
      S_PLAY_GAP: begin
        if (tick_end_s && (tick_q == GAP_LAST)) begin
          if (idx_q == last_idx_s) begin
            idx_d   = 4'd0;
            state_d = S_WAIT_KEY;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_PLAY_ON;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT_KEY: begin
        // A key arriving on the expiry cycle takes priority over the timeout.
        if (key_valid) begin
          key_d   = key_code;
          state_d = S_ECHO;
        end else if ((TIMEOUT_TICKS != 0) && tick_end_s && (tick_q == TO_LAST)) begin
          state_d = S_MISS;
        end else begin
          state_d = state_q;
        end
      end
      S_ECHO: begin
        if (tick_end_s && (tick_q == NOTE_LAST)) state_d = S_CHECK;
        else state_d = state_q;
      end
      S_CHECK: begin
        if (key_q != note_at(seq_q, idx_q)) begin
          state_d = S_MISS;
        end else if (idx_q != last_idx_s) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_WAIT_KEY;
        end else begin
          score_d = score_sum_s[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
          if (level_q == 4'(MAX_LEN)) begin
            win_d   = 1'b1;
            state_d = S_WIN;
          end else begin
            level_d = level_q + 4'd1;
            idx_d   = 4'd0;
            state_d = S_PLAY_ON;
          end
        end
      end
      S_MISS: begin
        lives_d = lives_q - 4'd1;
        if (lives_q <= 4'd1) begin
          over_d  = 1'b1;
          state_d = S_LOSE;
        end else begin
          idx_d   = 4'd0;
          state_d = S_PLAY_ON;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d != state_q) || !active_s) begin
      div_d  = '0;
      tick_d = '0;
    end else if (tick_end_s) begin
      div_d  = '0;
      tick_d = tick_q + TK_W'(1'b1);
    end else begin
      div_d  = div_q + DIV_W'(1'b1);
      tick_d = tick_q;
    end
  end

  // Output decode from the next state so every output register lines up with its state.
  always_comb begin
    tone_d = '0;
    led_d  = '0;
    case (state_d)
      S_PLAY_ON: tone_d = note_at(seq_d, idx_d);
      S_ECHO:    tone_d = key_d;
      default:   tone_d = '0;
    endcase
    for (int i = 0; i < LED_N; i++) begin
      led_d[i] = (tone_d == NW'(i + 1));
    end
    busy_d = !((state_d == S_IDLE) || (state_d == S_WIN) || (state_d == S_LOSE));
    acc_d  = (state_d == S_WAIT_KEY);
    miss_d = (state_d == S_MISS);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      tick_q   <= '0;
      seq_q    <= '0;
      idx_q    <= 4'd0;
      key_q    <= '0;
      level_q  <= 4'd0;
      lives_q  <= 4'd0;
      score_q  <= '0;
      loaded_q <= 1'b0;
      win_q    <= 1'b0;
      over_q   <= 1'b0;
      tone_q   <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      acc_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      seq_q    <= seq_d;
      idx_q    <= idx_d;
      key_q    <= key_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      loaded_q <= loaded_d;
      win_q    <= win_d;
      over_q   <= over_d;
      tone_q   <= tone_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      miss_q   <= miss_d;
    end
  end

  assign tone       = tone_q;
  assign led        = led_q;
  assign busy       = busy_q;
  assign accepting  = acc_q;
  assign level      = level_q;
  assign lives_left = lives_q;
  assign score      = score_q;
  assign miss       = miss_q;
  assign seq_loaded = loaded_q;
  assign game_win   = win_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_seq_game_core.sv
// Randomized bench for seq_game_core: a game-level model predicts playback,
// echo, score, lives and terminal states; the DUT is sampled on negedges.
module tb_seq_game_core;

  localparam int NOTE_CYC = 4;  // NOTE_TICKS * TICK_DIV
  localparam int GAP_CYC  = 2;  // GAP_TICKS * TICK_DIV
  localparam int TO_CYC   = 8;  // TIMEOUT_TICKS * TICK_DIV

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] seq_in = 16'h0000;
  logic        load = 1'b0, start = 1'b0, key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [3:0]  tone;
  logic [7:0]  led;
  logic        busy, accepting, miss, seq_loaded, game_win, game_over;
  logic [3:0]  level, lives_left;
  logic [7:0]  score;

  int n_chk = 0;
  int n_pass = 0;

  int m_note[4];
  int m_level, m_lives, m_score, m_idx;

  seq_game_core #(
    .NOTE_BITS(3), .MAX_LEN(4), .START_LEN(1), .TICK_DIV(2), .NOTE_TICKS(2),
    .GAP_TICKS(1), .TIMEOUT_TICKS(4), .LIVES(2), .SCORE_W(8)
  ) dut (
    .clk(clk), .reset(reset), .seq_in(seq_in), .load(load), .start(start),
    .key_valid(key_valid), .key_code(key_code), .tone(tone), .led(led),
    .busy(busy), .accepting(accepting), .level(level), .lives_left(lives_left),
    .score(score), .miss(miss), .seq_loaded(seq_loaded), .game_win(game_win),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_model_seq(input logic [15:0] s);
    for (int j = 0; j < 4; j++) m_note[j] = int'(s[4*j +: 3]) + 1;
  endtask

  // Expect the whole playback of the current level while injecting ignored noise.
  task automatic play_level();
    for (int j = 0; j < m_level; j++) begin
      for (int c = 0; c < NOTE_CYC + GAP_CYC; c++) begin
        if (c < NOTE_CYC) begin
          check("tone_on", tone, m_note[j]);
          check("led_on", led, 1 << (m_note[j] - 1));
        end else begin
          check("tone_gap", tone, 0);
        end
        check("busy_play", busy, 1);
        check("acc_play", accepting, 0);
        key_valid = ($urandom_range(0, 3) == 0);
        key_code  = 4'($urandom_range(0, 15));
        load      = ($urandom_range(0, 7) == 0);
        start     = ($urandom_range(0, 7) == 0);
        seq_in    = 16'($urandom);
        step();
      end
    end
    key_valid = 1'b0;
    load = 1'b0;
    start = 1'b0;
    check("acc_wait", accepting, 1);
    check("level_keep", level, m_level);
    check("lives_keep", lives_left, m_lives);
    m_idx = 0;
  endtask

  task automatic start_game(input bit with_load, input logic [15:0] s);
    if (with_load) begin
      seq_in = s;
      load = 1'b1;
      set_model_seq(s);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    load = 1'b0;
    m_level = 1; m_lives = 2; m_score = 0; m_idx = 0;
    check("start_level", level, m_level);
    check("start_lives", lives_left, m_lives);
    check("start_score", score, 0);
    check("start_win", game_win, 0);
    check("start_over", game_over, 0);
    play_level();
  endtask

  // act 0: correct key, 1: given key, 2: let the timeout expire.
  task automatic turn(input int act, input int key_in, output bit ended);
    int dly, key;
    bit ok;
    ended = 1'b0;
    if (act == 2) begin
      for (int c = 0; c < TO_CYC; c++) begin
        check("acc_to", accepting, 1);
        step();
      end
      ok = 1'b0;
    end else begin
      dly = $urandom_range(0, TO_CYC - 1);
      for (int c = 0; c < dly; c++) begin
        check("acc_hold", accepting, 1);
        step();
      end
      key = (act == 0) ? m_note[m_idx] : key_in;
      key_valid = 1'b1;
      key_code = 4'(key);
      step();
      key_valid = 1'b0;
      for (int c = 0; c < NOTE_CYC; c++) begin
        check("echo_tone", tone, key);
        check("echo_led", led, (key == 0) ? 0 : (1 << (key - 1)));
        step();
      end
      check("check_tone", tone, 0);
      step();
      ok = (key == m_note[m_idx]);
    end
    if (!ok) begin
      check("miss_pulse", miss, 1);
      step();
      check("miss_low", miss, 0);
      m_lives--;
      check("lives_miss", lives_left, m_lives);
      if (m_lives == 0) begin
        check("game_over", game_over, 1);
        check("busy_lose", busy, 0);
        ended = 1'b1;
      end else begin
        play_level();
      end
    end else if (m_idx < m_level - 1) begin
      m_idx++;
      check("acc_next", accepting, 1);
    end else begin
      m_score = m_score + m_level;
      if (m_score > 255) m_score = 255;
      check("score", score, m_score);
      if (m_level == 4) begin
        check("game_win", game_win, 1);
        check("busy_win", busy, 0);
        ended = 1'b1;
      end else begin
        m_level++;
        check("level_up", level, m_level);
        play_level();
      end
    end
  endtask

  task automatic finish_game();
    bit ended;
    ended = 1'b0;
    for (int t = 0; t < 40 && !ended; t++) turn(0, 0, ended);
    check("game_ended", int'(ended), 1);
  endtask

  initial begin
    bit ended;
    int r;
    step();
    step();
    check("rst_tone", tone, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_lives", lives_left, 0);
    check("rst_score", score, 0);
    check("rst_loaded", seq_loaded, 0);
    check("rst_flags", {miss, accepting, game_win, game_over}, 0);
    reset = 1'b1;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    check("nostart_busy", busy, 0);
    check("nostart_tone", tone, 0);

    seq_in = 16'h3210;
    load = 1'b1;
    step();
    load = 1'b0;
    set_model_seq(16'h3210);
    check("loaded", seq_loaded, 1);
    start_game(1'b0, 16'h0000);
    finish_game();
    check("win_score10", score, 10);

    start_game(1'b1, 16'h3210);
    turn(1, 3, ended);
    check("lose_lives1", lives_left, 1);
    turn(1, 3, ended);
    check("lose_ended", int'(ended), 1);
    check("lose_lives0", lives_left, 0);

    start_game(1'b1, 16'h0123);
    turn(2, 0, ended);
    finish_game();

    for (int g = 0; g < 6; g++) begin
      start_game(($urandom_range(0, 1) == 1), 16'($urandom));
      ended = 1'b0;
      for (int t = 0; t < 60 && !ended; t++) begin
        r = $urandom_range(0, 15);
        turn((r < 11) ? 0 : (r < 14) ? 1 : 2, $urandom_range(0, 8), ended);
      end
      check("rand_ended", int'(ended), 1);
    end

    seq_in = 16'h3210;
    load = 1'b1;
    start = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    step();
    check("pre_rst_tone", tone, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_tone", tone, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_lives", lives_left, 0);
    check("mid_rst_loaded", seq_loaded, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("post_rst_nostart", busy, 0);
    step();
    check("post_rst_tone", tone, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_game_core.md
# seq_game_core

Parametrised successor to the keypad memory-game core. It plays a stored note sequence of growing length on the piezo/LED outputs, then checks the player's keypad echo note by note. It adds:
- configurable note width, sequence depth and tone/gap/echo timing from a deterministic prescaler;
- an input timeout;
- a lives counter, a saturating score, and distinct win/lose terminal states.

It sits between the keypad/data-load front end and the piezo/LED drivers.

## Interface
- NOTE_BITS, 3: bits of each stored note field; playable notes are 1..2^NOTE_BITS.
- MAX_LEN, 8: sequence depth (slots); winning length.
- START_LEN, 1: sequence length played at game start (1..MAX_LEN).
- TICK_DIV, 5000000: clk cycles per tick.
- NOTE_TICKS, 3: ticks a note sounds, in playback and in echo.
- GAP_TICKS, 1: silent ticks after each played note.
- TIMEOUT_TICKS, 20: ticks allowed per keypad entry; 0 disables the timeout.
- LIVES, 3: misses allowed before game over (≥1).
- SCORE_W, 8: score width.

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is synchronous and active-low.
- seq_in  in  4*MAX_LEN  slot i in bits [4i+NOTE_BITS-1:4i]; remaining bits of each nibble ignored.
- load  in  1  capture seq_in.
- start  in  1  begin a game.
- key_valid  in  1  one-cycle keypad strobe.
- key_code  in  NOTE_BITS+1  pressed note.
- tone  out  NOTE_BITS+1  piezo note; 0 = silent.
- led  out  2^NOTE_BITS  one-hot: bit (tone-1) set when tone≠0, else all 0.
- busy  out  1  high in any state except IDLE/WIN/LOSE.
- accepting  out  1  high only in WAIT_KEY.
- level  out  4  current sequence length.
- lives_left  out  4  remaining lives.
- score  out  SCORE_W  accumulated score.
- miss  out  1  one-cycle pulse per miss.
- seq_loaded  out  1  a sequence has been captured.
- game_win  out  1  level held in WIN.
- game_over  out  1  level held in LOSE.

## Operation
- Reset (reset==0 at a clk edge): state IDLE; all outputs 0; sequence store 0; prescaler 0. Reset overrides every other input.
- Note value of slot i = field + 1.
- load is accepted only when busy==0: seq_in is stored and seq_loaded is set. Load during play is ignored.
- start is accepted only when busy==0 and seq_loaded==1, or when load is asserted in the same cycle; the new sequence is then used. On start: level=START_LEN, lives_left=LIVES, score=0, game_win=game_over=0, idx=0, enter PLAY_ON.

States and transitions:
- PLAY_ON: tone = note[idx]. After NOTE_TICKS go to PLAY_GAP.
- PLAY_GAP: tone=0. After GAP_TICKS: if idx==level-1, set idx=0 and go to WAIT_KEY; else idx+1 and go to PLAY_ON.
- WAIT_KEY: tone=0. key_valid captures key_code and goes to ECHO. TIMEOUT_TICKS elapsed with no key: MISS.
- ECHO: tone = captured key. After NOTE_TICKS go to CHECK.
- CHECK (1 cycle, tone=0):
  - key ≠ note[idx] (key 0 is always wrong): MISS.
  - match with idx<level-1: idx+1, go to WAIT_KEY.
  - match with idx==level-1: score += level, saturating at 2^SCORE_W-1. If level==MAX_LEN go to WIN; else level+1, idx=0, go to PLAY_ON.
- MISS (1 cycle): miss=1; lives_left-1. If the result is 0 go to LOSE; else idx=0, replay the same level from PLAY_ON.
- WIN / LOSE: tone=0; game_win / game_over held high. Idle otherwise until start or reset.

Input rules:
- key_valid outside WAIT_KEY is ignored, not queued.
- A key_valid on the same cycle as a timeout expiry wins; no miss is taken.

## Timing
- Prescaler clears on every state change. A state lasting N ticks therefore lasts exactly N*TICK_DIV cycles.
- All outputs are registered.
- tone for PLAY_ON/ECHO is valid the cycle after state entry and drops the cycle after exit.
- Playback of level L: L*(NOTE_TICKS+GAP_TICKS)*TICK_DIV cycles.
- start to first tone: 1 cycle.
- Keypad path: key_valid to echo tone is 1 cycle. ECHO lasts NOTE_TICKS*TICK_DIV cycles, then CHECK 1 cycle; the next state is entered on the following cycle.
- miss is high for exactly one cycle.
- Reset mid-operation: the state at the next edge is IDLE with all outputs 0.

## Test plan
Bench parameters: TICK_DIV=2, NOTE_TICKS=2, GAP_TICKS=1, MAX_LEN=4, START_LEN=1, LIVES=2, TIMEOUT_TICKS=4.
- Load 0x3210, start -> tone=1 for 4 cycles, then 0 for 2; accepting=1; level=1, lives_left=2, score=0.
- Key 1 -> echo tone=1 for 4 cycles; level=2, score=1; replay 1,2.
- Full correct play to level 4 -> game_win=1, score=10 (1+2+3+4), busy=0.
- Wrong key 3 at level 1 -> miss pulse, lives_left=1, replay; second wrong key -> game_over=1, lives_left=0.
- No key for 8 cycles in WAIT_KEY -> miss; key_valid during playback ignored (level and lives unchanged).
- reset=0 mid PLAY_ON -> next cycle tone=0, all outputs 0, seq_loaded=0; start without load ignored.
